sha256_msg_padder: RTL and testbench

Front-end producer for the SHA-256 datapath. It accepts a raw big-endian message as a stream of 32-bit words, forwards the message words and appends SHA-256 padding. The padding is the 0x80 marker byte, zero fill and the 64-bit big-endian bit length. The output is a stream of 16-word chunks that feeds the chunk-process (message schedule) load port one word per transfer. It owns all message-length bookkeeping, so downstream blocks only ever see complete 512-bit chunks.

---
 rtl/sha256_msg_padder_if.sv | 30 +++
 rtl/sha256_msg_padder.sv | 181 ++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_padder_if.sv
// Stream bundle between a message source, the SHA-256 padder and the chunk
// consumer.
//   in_*  : raw message words into the padder (valid/ready, last, byte keep)
//   out_* : padded 16-word chunk stream out of the padder (valid/ready,
//           first = word 0 of a chunk, last = final length word)
// Modports:
//   master : the padder, which masters the padded chunk stream
//   slave  : the environment that feeds messages and sinks chunks
interface sha256_msg_padder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [1:0]  in_keep;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_first;
  logic        out_last;

  modport master (
    input  in_valid, in_data, in_last, in_keep, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last
  );

  modport slave (
    output in_valid, in_data, in_last, in_keep, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder. Forwards big-endian 32-bit message words and appends
// the 0x80 marker, zero fill and the 64-bit big-endian bit length so that the
// output is always a whole number of 16-word (512-bit) chunks.
// Ports:
//   clk   : clock, all state changes on posedge
//   rst_n : asynchronous active-low reset
//   clear : synchronous abort/restart, same effect as reset, highest priority
//   bus   : sha256_msg_padder_if.master (message in, padded chunk words out)
//   done  : one-cycle pulse the cycle after the out_last word transfers
//   err   : sticky protocol error
// Build option: define SHA256_PADDER_ERR_CHECK_EN to enable the err checks
// (keep != 0 on a non-last word, bit-length overflow). Otherwise err is 0.
module sha256_msg_padder (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  sha256_msg_padder_if.master        bus,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [2:0] {StData, StPad, StZero, StLenH, StLenL} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [63:0] blen_q, blen_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_first_q, out_first_d;
  logic        out_last_q, out_last_d;
  logic        done_q, done_d;

  logic        load;
  logic        in_xfer;
  logic        ld;
  logic [31:0] ld_data;
  logic [31:0] last_word;
  logic [63:0] blen_add;

  // The output register may take a new word when empty or being drained.
  assign load        = !out_valid_q | bus.out_ready;
  assign bus.in_ready = rst_n & !clear & (state_q == StData) & load;
  assign in_xfer     = bus.in_valid & bus.in_ready;

  // Partial last word: keep the leading data bytes, marker right after them.
  always_comb begin
    last_word = bus.in_data;
    case (bus.in_keep)
      2'd1:    last_word = {bus.in_data[31:24], 24'h800000};
      2'd2:    last_word = {bus.in_data[31:16], 16'h8000};
      2'd3:    last_word = {bus.in_data[31:8], 8'h80};
      default: last_word = bus.in_data;
    endcase
  end

  // Non-last words always count as full words.
  assign blen_add = (bus.in_last && bus.in_keep != 2'd0) ? {59'd0, bus.in_keep, 3'd0} : 64'd32;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    blen_d      = blen_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    done_d      = out_valid_q & bus.out_ready & out_last_q;
    ld          = 1'b0;
    ld_data     = 32'h0;

    if (load) begin
      unique case (state_q)
        StData: begin
          if (in_xfer) begin
            ld      = 1'b1;
            ld_data = bus.in_last ? last_word : bus.in_data;
            blen_d  = blen_q + blen_add;
            if (bus.in_last) begin
              if (bus.in_keep == 2'd0)  state_d = StPad;
              else if (wcnt_q == 4'd13) state_d = StLenH;
              else                      state_d = StZero;
            end
          end
        end
        StPad: begin
          ld      = 1'b1;
          ld_data = 32'h8000_0000;
          state_d = (wcnt_q == 4'd13) ? StLenH : StZero;
        end
        StZero: begin
          ld      = 1'b1;
          ld_data = 32'h0;
          if (wcnt_q == 4'd13) state_d = StLenH;
        end
        StLenH: begin
          ld      = 1'b1;
          ld_data = blen_q[63:32];
          state_d = StLenL;
        end
        StLenL: begin
          ld      = 1'b1;
          ld_data = blen_q[31:0];
          state_d = StData;
          blen_d  = 64'd0;
        end
        default: state_d = StData;
      endcase
      out_valid_d = ld;
    end

    if (ld) begin
      out_data_d  = ld_data;
      out_first_d = (wcnt_q == 4'd0);
      out_last_d  = (state_q == StLenL);
      wcnt_d      = wcnt_q + 4'd1;
    end

    if (clear) begin
      state_d     = StData;
      wcnt_d      = 4'd0;
      blen_d      = 64'd0;
      out_valid_d = 1'b0;
      out_data_d  = 32'h0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StData;
      wcnt_q      <= 4'd0;
      blen_q      <= 64'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      blen_q      <= blen_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign done          = done_q;

`ifdef SHA256_PADDER_ERR_CHECK_EN
  logic        err_q, err_d;
  logic [64:0] blen_sum;

  // Carry out of the 64-bit length means the message hit 2^61 bytes.
  assign blen_sum = {1'b0, blen_q} + {1'b0, blen_add};

  always_comb begin
    err_d = err_q;
    if (in_xfer && ((!bus.in_last && bus.in_keep != 2'd0) || blen_sum[64])) err_d = 1'b1;
    if (clear) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: directed messages, a byte-level padding model,
// and a per-cycle compare process on the output stream, done and err.
module tb_sha256_msg_padder;
  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic done;
  logic err;

  always #5 clk = ~clk;

  sha256_msg_padder_if bus ();

  sha256_msg_padder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus),
    .done  (done),
    .err   (err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        first;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        built[$];
  exp_t        e_cur;
  exp_t        hold;
  logic [31:0] msg[0:63];
  logic        err_exp   = 1'b0;
  logic        done_pend = 1'b0;
  logic        hold_v    = 1'b0;
  int          checks    = 0;
  int          errors    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Padding from first principles: message bytes, 0x80, zeros to 56 mod 64,
  // then the 8-byte big-endian bit length; regrouped into 32-bit words.
  task automatic build(input int nbytes);
    logic [7:0]  b[$];
    logic [31:0] w;
    logic [63:0] bits;
    exp_t        e;
    int          n;
    built.delete();
    for (int i = 0; i < nbytes; i++) begin
      w = msg[i / 4] >> (24 - 8 * (i % 4));
      b.push_back(w[7:0]);
    end
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    bits = 64'(nbytes) * 64'd8;
    for (int k = 7; k >= 0; k--) b.push_back(bits[8 * k +: 8]);
    n = b.size() / 4;
    for (int i = 0; i < n; i++) begin
      e.data  = {b[4 * i], b[4 * i + 1], b[4 * i + 2], b[4 * i + 3]};
      e.first = (i % 16 == 0);
      e.last  = (i == n - 1);
      built.push_back(e);
    end
  endtask

  // Enter at posedge+1; returns at posedge+1 after the last word is accepted.
  task automatic send_msg(input int nbytes, input int bad_idx);
    int nwords;
    int budget;
    logic got;
    nwords = (nbytes + 3) / 4;
    build(nbytes);
    foreach (built[i]) exp_q.push_back(built[i]);
    for (int i = 0; i < nwords; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = msg[i];
      bus.in_last  = (i == nwords - 1);
      if (i == nwords - 1) bus.in_keep = 2'(nbytes % 4);
      else                 bus.in_keep = (i == bad_idx) ? 2'd2 : 2'd0;
      budget = 0;
      got    = 1'b0;
      while (!got) begin
        @(negedge clk);
        if (bus.in_ready) got = 1'b1;
        else begin
          budget++;
          if (budget > 200) begin
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
            $fatal(1, "input stalled");
          end
        end
        @(posedge clk);
        #1;
      end
`ifdef SHA256_PADDER_ERR_CHECK_EN
      if (i == bad_idx) err_exp = 1'b1;
`endif
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_keep  = 2'd0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear   = 1'b1;
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // Output compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n || clear) begin
      if (clear) exp_q.delete();
      done_pend = 1'b0;
      hold_v    = 1'b0;
    end else begin
      chk1("done", done, done_pend);
      chk1("err", err, err_exp);
      if (hold_v) begin
        chk1("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", bus.out_data, hold.data);
        chk1("hold_first", bus.out_first, hold.first);
        chk1("hold_last", bus.out_last, hold.last);
      end
      done_pend = 1'b0;
      hold_v    = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", bus.out_data);
        end else begin
          e_cur = exp_q.pop_front();
          chk("out_data", bus.out_data, e_cur.data);
          chk1("out_first", bus.out_first, e_cur.first);
          chk1("out_last", bus.out_last, e_cur.last);
          done_pend = bus.out_last;
        end
      end else if (bus.out_valid) begin
        hold_v = 1'b1;
        hold   = {bus.out_data, bus.out_first, bus.out_last};
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_last   = 1'b0;
    bus.in_keep   = 2'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk1("rst_out_first", bus.out_first, 1'b0);
    chk1("rst_out_last", bus.out_last, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // "abc"
    msg[0] = 32'h6162_6300;
    build(3);
    chk("pin_abc_size", 32'(built.size()), 32'd16);
    chk("pin_abc_w0", built[0].data, 32'h6162_6380);
    chk("pin_abc_w15", built[15].data, 32'h0000_0018);
    send_msg(3, -1);

    // 13 and 14 full words, back to back
    for (int i = 0; i < 14; i++) msg[i] = 32'h0101_0101 * (i + 1);
    build(52);
    chk("pin_13_w13", built[13].data, 32'h8000_0000);
    chk("pin_13_w15", built[15].data, 32'h0000_01A0);
    send_msg(52, -1);
    build(56);
    chk("pin_14_size", 32'(built.size()), 32'd32);
    chk("pin_14_w14", built[14].data, 32'h8000_0000);
    chk("pin_14_w31", built[31].data, 32'h0000_01C0);
    send_msg(56, -1);
    wait_drain();

    // Backpressure in the data phase and again in the padding phase
    fork
      send_msg(20, -1);
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Abort during zero fill, then "abc" with junk in the unused byte
    msg[0] = 32'h1111_2222;
    msg[1] = 32'h3333_4444;
    send_msg(8, -1);
    repeat (4) @(posedge clk);
    #1;
    pulse_clear();
    @(negedge clk);
    chk1("clear_out_valid", bus.out_valid, 1'b0);
    chk1("clear_done", done, 1'b0);
    @(posedge clk);
    #1;
    msg[0] = 32'h6162_63AA;
    send_msg(3, -1);
    wait_drain();

    // keep != 0 on a non-last word
    msg[0] = 32'hDEAD_BEEF;
    msg[1] = 32'h0BAD_F00D;
    send_msg(8, 0);
    wait_drain();
    @(negedge clk);
`ifdef SHA256_PADDER_ERR_CHECK_EN
    chk1("err_sticky", err, 1'b1);
`else
    chk1("err_tied_low", err, 1'b0);
`endif
    @(posedge clk);
    #1;
    pulse_clear();
    @(negedge clk);
    chk1("err_after_clear", err, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
